error_sum_accumulator: RTL and testbench
========================================

# error_sum_accumulator

Downstream fitness stage for chromosome evaluation. For each sequence the chromosome processor finishes, this block compares the 8-bit chromosome output against the expected output under the valid-output mask. It accumulates per-output-bit mismatch counts and a total mismatch count. It reports completion to the HPS through the same start/done/done-feedback handshake used by the chromosome processing controls, and it drives the eight 32-bit error-sum PIO exports.

## Interface
- NUM_OUTPUTS, 8, output bits compared per sequence (one error lane each)
- SUM_WIDTH, 32, width of each per-lane error sum and of the total
- CNT_WIDTH, 8, width of the sequence count and index

Ports:
- iClock  in  1  system clock (CLOCK_50 domain)
- iReset_n  in  1  asynchronous active-low reset
- iStart  in  1  begin a new evaluation; sampled only in IDLE
- iSequencesToProcess  in  CNT_WIDTH  sequences to accumulate; latched on accepted iStart
- iSampleValid  in  1  one chromosome result presented this cycle
- iChromOutput  in  NUM_OUTPUTS  chromosome output for the current sequence
- iExpectedOutput  in  NUM_OUTPUTS  expected output for the current sequence
- iValidMask  in  NUM_OUTPUTS  1 = bit participates in scoring
- oSampleReady  out  1  high only in ACCUM; a sample transfers when iSampleValid && oSampleReady
- oSequenceIndex  out  CNT_WIDTH  number of samples accepted so far in this run
- oErrorSums  out  NUM_OUTPUTS*SUM_WIDTH  lane i occupies bits [i*SUM_WIDTH +: SUM_WIDTH]
- oTotalErrors  out  SUM_WIDTH  sum over all lanes
- oDone  out  1  high throughout DONE
- iDoneFeedback  in  1  HPS acknowledges that the results have been read
- oState  out  2  IDLE=0, ACCUM=1, DONE=2

## Operation
- Mismatch vector: m = (iChromOutput ^ iExpectedOutput) & iValidMask.
- On each transfer:
  - lane sum i += m[i];
  - total += popcount(m), which ranges 0..NUM_OUTPUTS;
  - oSequenceIndex += 1.
- IDLE:
  - oSampleReady=0 and iSampleValid is ignored.
  - On iStart: clear all sums and the index, and latch the count. Go to DONE if the count is 0; otherwise go to ACCUM.
- ACCUM:
  - Accept samples.
  - The transfer that makes the index equal the latched count moves the block to DONE on the same edge, so oSampleReady is 0 in the next cycle.
  - iStart is ignored.
- DONE:
  - Sums, total and index are held stable.
  - iDoneFeedback moves the block to IDLE.
  - iStart is ignored, including when it coincides with iDoneFeedback.
- Outputs keep their values through IDLE until the next accepted iStart.
- Reset (asynchronous, including mid-run): state IDLE; all sums, the total, the index and oDone = 0; oSampleReady = 0. The run is discarded.

## Timing
- All outputs are registered.
- A transfer at edge N is visible on oErrorSums, oTotalErrors and oSequenceIndex after edge N, giving 1-cycle latency.
- Back-to-back transfers every cycle are supported, with no bubbles.
- oDone rises in the cycle after the final transfer edge. With count 0 it rises in the cycle after the accepted iStart.
- iDoneFeedback is level-sensitive: oDone falls the cycle after it is sampled high in DONE.
- Latched count semantics: a change on iSequencesToProcess during ACCUM has no effect.

## Configuration
- ERROR_SUM_SATURATE_EN defined:
  - Each lane sum and the total saturate at all-ones instead of wrapping.
  - The saturation check is applied per lane and separately to the total.
- Not defined: sums wrap modulo 2^SUM_WIDTH.
- Neither setting changes state-machine behaviour or timing.

## Structure
- Package error_sum_pkg holds:
  - the state enum (IDLE/ACCUM/DONE, 2 bits);
  - default width constants NUM_OUTPUTS_DEF=8, SUM_WIDTH_DEF=32, CNT_WIDTH_DEF=8.
- One sub-module, error_lane_counter, instantiated NUM_OUTPUTS times. It is a SUM_WIDTH-bit counter with:
  - clear;
  - increment enable (transfer && m[i]);
  - saturation under the macro.
- The top level holds:
  - the FSM;
  - the index counter;
  - the popcount adder feeding the total register.

## Test plan
- Count 3, three samples with chrom=0xFF, expected=0x00, mask=0xFF -> every lane = 3, total = 24, index = 3, oDone rises one cycle after the 3rd transfer.
- Count 2, chrom=0x0F, expected=0x00, mask=0x03 on both -> lanes 0,1 = 2, lanes 2..7 = 0, total = 4.
- Count 0 start -> DONE next cycle with all sums 0; iDoneFeedback -> IDLE next cycle, sums held at 0.
- iSampleValid pulses in IDLE and DONE, and iStart during ACCUM -> no change to sums, index or count.
- Assert iReset_n low mid-ACCUM after 5 of 10 samples -> IDLE immediately, all outputs 0; a new iStart runs cleanly.
- Preload a lane near its limit with SUM_WIDTH=4, 20 mismatching samples -> lane stops at 15 with ERROR_SUM_SATURATE_EN defined, and shows 20 mod 16 = 4 without it.

Source files
------------

// File: rtl/error_sum_accumulator_pkg.sv
// Shared types and default widths for the error-sum accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package error_sum_pkg;

  localparam int NUM_OUTPUTS_DEF = 8;
  localparam int SUM_WIDTH_DEF   = 32;
  localparam int CNT_WIDTH_DEF   = 8;

  // Encoding is visible to the HPS through oState, so values are pinned.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/error_sum_accumulator_if.sv
// Sample stream from the chromosome processor into the accumulator.
// Latency: n/a (wires only).
// Backpressure: oSampleReady gates transfers; a sample moves on valid && ready.
interface error_sum_accumulator_if
  import error_sum_pkg::*;
#(
  parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF
) ();

  logic                   iSampleValid;
  logic [NUM_OUTPUTS-1:0] iChromOutput;
  logic [NUM_OUTPUTS-1:0] iExpectedOutput;
  logic [NUM_OUTPUTS-1:0] iValidMask;
  logic                   oSampleReady;

  modport master (
    output iSampleValid, iChromOutput, iExpectedOutput, iValidMask,
    input  oSampleReady
  );

  modport slave (
    input  iSampleValid, iChromOutput, iExpectedOutput, iValidMask,
    output oSampleReady
  );

endinterface

// File: rtl/error_sum_accumulator_lane_counter.sv
// Per-output-bit mismatch counter; wraps, or sticks at all-ones with ERROR_SUM_SATURATE_EN.
// Latency: increment visible 1 cycle after the enabling edge.
// Backpressure: none; counts whenever i_inc is high, clear has priority.
module error_lane_counter
  import error_sum_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [SUM_WIDTH-1:0] o_count
);

  logic [SUM_WIDTH-1:0] r_count;

  // Lane count register: clear on a new run, otherwise step by one on a mismatch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
`ifdef ERROR_SUM_SATURATE_EN
      if (r_count != {SUM_WIDTH{1'b1}}) begin
        r_count <= r_count + SUM_WIDTH'(1);
      end
`else
      r_count <= r_count + SUM_WIDTH'(1);
`endif
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/error_sum_accumulator.sv
// Fitness stage: counts masked chrom/expected mismatches per lane and in total (ERROR_SUM_SATURATE_EN = saturating sums).
// Latency: 1 cycle from transfer edge to sums/total/index; oDone the cycle after the final transfer.
// Backpressure: oSampleReady high only while accumulating; no bubbles between back-to-back transfers.
module error_sum_accumulator
  import error_sum_pkg::*;
#(
  parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                             iClock,
  input  logic                             iReset_n,
  input  logic                             iStart,
  input  logic [CNT_WIDTH-1:0]             iSequencesToProcess,
  error_sum_accumulator_if.slave           s_if,
  output logic [CNT_WIDTH-1:0]             oSequenceIndex,
  output logic [NUM_OUTPUTS*SUM_WIDTH-1:0] oErrorSums,
  output logic [SUM_WIDTH-1:0]             oTotalErrors,
  output logic                             oDone,
  input  logic                             iDoneFeedback,
  output logic [1:0]                       oState
);

  localparam int POP_W = $clog2(NUM_OUTPUTS + 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   w_clear;
  logic                   w_xfer;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_idx;
  logic [CNT_WIDTH-1:0]   w_idx_inc;
  logic [SUM_WIDTH-1:0]   r_total;
  logic [SUM_WIDTH-1:0]   w_total_nxt;
  logic [NUM_OUTPUTS-1:0] w_mis;
  logic [POP_W-1:0]       w_pop;
  logic                   r_ready;
  logic                   r_done;

  assign w_mis     = (s_if.iChromOutput ^ s_if.iExpectedOutput) & s_if.iValidMask;
  assign w_idx_inc = r_idx + CNT_WIDTH'(1);

  // State register.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the clear/transfer strobes; start only counts in IDLE,
  // and the final transfer leaves ACCUM on its own edge.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_clear     = 1'b1;
          w_state_nxt = (iSequencesToProcess == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        w_xfer = s_if.iSampleValid;
        if (w_xfer && (w_idx_inc == r_count)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (iDoneFeedback) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready and done are flopped from the next state so they leave on clean edges.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == ST_ACCUM);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Latch the run length on an accepted start; later input changes are ignored.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_count <= '0;
    end else if (w_clear) begin
      r_count <= iSequencesToProcess;
    end
  end

  // Sequence index: number of samples taken in this run.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_idx <= '0;
    end else if (w_clear) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      r_idx <= w_idx_inc;
    end
  end

  // Popcount of the masked mismatch vector.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      w_pop = w_pop + POP_W'(w_mis[i]);
    end
  end

`ifdef ERROR_SUM_SATURATE_EN
  logic [SUM_WIDTH:0] w_total_ext;

  // One spare bit catches overflow so the total can pin at all-ones.
  always_comb begin
    w_total_ext = {1'b0, r_total} + {{(SUM_WIDTH + 1 - POP_W){1'b0}}, w_pop};
    w_total_nxt = w_total_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : w_total_ext[SUM_WIDTH-1:0];
  end
`else
  // Wrapping total.
  always_comb begin
    w_total_nxt = r_total + {{(SUM_WIDTH - POP_W){1'b0}}, w_pop};
  end
`endif

  // Total mismatch register.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_total <= '0;
    end else if (w_clear) begin
      r_total <= '0;
    end else if (w_xfer) begin
      r_total <= w_total_nxt;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
      error_lane_counter #(
        .SUM_WIDTH (SUM_WIDTH)
      ) u_lane (
        .i_clk   (iClock),
        .i_rst_n (iReset_n),
        .i_clear (w_clear),
        .i_inc   (w_xfer & w_mis[g]),
        .o_count (oErrorSums[g*SUM_WIDTH +: SUM_WIDTH])
      );
    end
  endgenerate

  assign s_if.oSampleReady = r_ready;
  assign oDone             = r_done;
  assign oSequenceIndex    = r_idx;
  assign oTotalErrors      = r_total;
  assign oState            = r_state;

endmodule

// File: tb/tb_error_sum_accumulator.sv
// Bench for error_sum_accumulator: reference model compared every cycle, plus literal spot values.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: stimulus follows the expected ready pattern; a 4-bit instance covers wrap/saturation.
module tb_error_sum_accumulator;
  import error_sum_pkg::*;

  localparam int NO  = 8;
  localparam int SW  = 32;
  localparam int CW  = 8;
  localparam int SW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start, fb;
  logic [CW-1:0]   seq_cnt;
  logic [CW-1:0]   idx;
  logic [NO*SW-1:0] sums;
  logic [SW-1:0]   total;
  logic            done;
  logic [1:0]      st;

  logic            start2, fb2;
  logic [CW-1:0]   seq_cnt2;
  logic [CW-1:0]   idx2;
  logic [NO*SW2-1:0] sums2;
  logic [SW2-1:0]  total2;
  logic            done2;
  logic [1:0]      st2;

  error_sum_accumulator_if #(.NUM_OUTPUTS(NO)) sif ();
  error_sum_accumulator_if #(.NUM_OUTPUTS(NO)) sif2 ();

  error_sum_accumulator #(.NUM_OUTPUTS(NO), .SUM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .iClock(clk), .iReset_n(rst_n), .iStart(start), .iSequencesToProcess(seq_cnt),
    .s_if(sif.slave), .oSequenceIndex(idx), .oErrorSums(sums), .oTotalErrors(total),
    .oDone(done), .iDoneFeedback(fb), .oState(st)
  );

  error_sum_accumulator #(.NUM_OUTPUTS(NO), .SUM_WIDTH(SW2), .CNT_WIDTH(CW)) dut2 (
    .iClock(clk), .iReset_n(rst_n), .iStart(start2), .iSequencesToProcess(seq_cnt2),
    .s_if(sif2.slave), .oSequenceIndex(idx2), .oErrorSums(sums2), .oTotalErrors(total2),
    .oDone(done2), .iDoneFeedback(fb2), .oState(st2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  // phase: 0 idle, 1 accumulating, 2 done
  int     m_phase = 0;
  longint m_sum[NO];
  longint m_tot = 0;
  int     m_idx = 0;
  int     m_cnt = 0;

  function automatic longint acc(input longint a, input longint b, input int w);
    longint mx = (longint'(1) << w) - 1;
    longint s  = a + b;
`ifdef ERROR_SUM_SATURATE_EN
    if (s > mx) s = mx;
`else
    s = s & mx;
`endif
    return s;
  endfunction

  function automatic int popc(input logic [NO-1:0] v);
    int c = 0;
    for (int i = 0; i < NO; i++) c += int'(v[i]);
    return c;
  endfunction

  logic [NO-1:0] mis;
  assign mis = (sif.iChromOutput ^ sif.iExpectedOutput) & sif.iValidMask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      for (int i = 0; i < NO; i++) m_sum[i] <= 0;
      m_tot <= 0;
      m_idx <= 0;
      m_cnt <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          for (int i = 0; i < NO; i++) m_sum[i] <= 0;
          m_tot   <= 0;
          m_idx   <= 0;
          m_cnt   <= int'(seq_cnt);
          m_phase <= (seq_cnt == 0) ? 2 : 1;
        end
        1: if (sif.iSampleValid) begin
          for (int i = 0; i < NO; i++) m_sum[i] <= acc(m_sum[i], longint'(mis[i]), SW);
          m_tot <= acc(m_tot, longint'(popc(mis)), SW);
          m_idx <= m_idx + 1;
          if (m_idx + 1 == m_cnt) m_phase <= 2;
        end
        default: if (fb) m_phase <= 0;
      endcase
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", 64'(st), 64'(m_phase));
      chk("done", 64'(done), 64'(m_phase == 2));
      chk("ready", 64'(sif.oSampleReady), 64'(m_phase == 1));
      chk("index", 64'(idx), 64'(m_idx));
      chk("total", 64'(total), 64'(m_tot));
      for (int i = 0; i < NO; i++)
        chk($sformatf("lane%0d", i), 64'(sums[i*SW +: SW]), 64'(m_sum[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] c, input logic [7:0] e, input logic [7:0] m);
    sif.iSampleValid    = v;
    sif.iChromOutput    = c;
    sif.iExpectedOutput = e;
    sif.iValidMask      = m;
  endtask

  task automatic fb_pulse();
    fb = 1'b1;
    step(1);
    fb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fb = 1'b0; seq_cnt = '0;
    start2 = 1'b0; fb2 = 1'b0; seq_cnt2 = '0;
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    sif2.iSampleValid = 1'b0; sif2.iChromOutput = '0;
    sif2.iExpectedOutput = '0; sif2.iValidMask = '0;
    step(2);
    chk_on = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    @(negedge clk);
    chk("reset_total", 64'(total), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // Count 3, all lanes mismatch on every sample.
    seq_cnt = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    drv(1'b1, 8'hFF, 8'h00, 8'hFF);
    step(2);
    @(negedge clk);
    chk("t1_done_early", 64'(done), 64'd0);
    step(1);
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_total", 64'(total), 64'd24);
    chk("t1_index", 64'(idx), 64'd3);
    chk("t1_lane7", 64'(sums[7*SW +: SW]), 64'd3);
    fb_pulse();
    @(negedge clk);
    chk("t1_idle_hold", 64'(total), 64'd24);

    // Count 2, mask limits scoring to lanes 0 and 1.
    seq_cnt = 8'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    drv(1'b1, 8'h0F, 8'h00, 8'h03);
    step(2);
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t2_lane0", 64'(sums[0 +: SW]), 64'd2);
    chk("t2_lane1", 64'(sums[SW +: SW]), 64'd2);
    chk("t2_lane2", 64'(sums[2*SW +: SW]), 64'd0);
    chk("t2_total", 64'(total), 64'd4);
    fb_pulse();

    // Count 0: straight to DONE with cleared sums.
    seq_cnt = 8'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    @(negedge clk);
    chk("t3_state", 64'(st), 64'd2);
    chk("t3_total", 64'(total), 64'd0);
    fb_pulse();
    @(negedge clk);
    chk("t3_idle", 64'(st), 64'd0);

    // Samples in IDLE, start and count changes during ACCUM, gapped valid.
    drv(1'b1, 8'hFF, 8'h00, 8'hFF);
    step(2);
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    seq_cnt = 8'd4; start = 1'b1;
    step(1);
    seq_cnt = 8'd1;
    for (int k = 0; k < 8; k++) begin
      drv(1'(k % 2), 8'hA5 ^ 8'(k), 8'h3C, 8'hF0 | 8'(k));
      step(1);
    end
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4_total", 64'(total), 64'd12);
    chk("t4_index", 64'(idx), 64'd4);
    chk("t4_lane7", 64'(sums[7*SW +: SW]), 64'd4);
    chk("t4_lane1", 64'(sums[SW +: SW]), 64'd2);
    drv(1'b1, 8'hFF, 8'h00, 8'hFF);
    step(2);
    fb = 1'b1;
    step(1);
    fb = 1'b0; start = 1'b0;
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    step(2);
    @(negedge clk);
    chk("t4_hold_total", 64'(total), 64'd12);
    chk("t4_idle", 64'(st), 64'd0);

    // Reset after 5 of 10 samples, then a clean run.
    seq_cnt = 8'd10; start = 1'b1;
    step(1);
    start = 1'b0;
    drv(1'b1, 8'hFF, 8'h00, 8'hFF);
    step(5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_state", 64'(st), 64'd0);
    chk("t5_rst_total", 64'(total), 64'd0);
    chk("t5_rst_index", 64'(idx), 64'd0);
    chk("t5_rst_ready", 64'(sif.oSampleReady), 64'd0);
    step(1);
    rst_n = 1'b1;
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    step(1);
    seq_cnt = 8'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    drv(1'b1, 8'h81, 8'h01, 8'hFF);
    step(2);
    drv(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_lane7", 64'(sums[7*SW +: SW]), 64'd2);
    chk("t5_lane0", 64'(sums[0 +: SW]), 64'd0);
    chk("t5_total", 64'(total), 64'd2);
    chk("t5_done", 64'(done), 64'd1);
    fb_pulse();

    // 4-bit sums: 20 mismatches on lane 0.
    seq_cnt2 = 8'd20; start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    sif2.iSampleValid = 1'b1; sif2.iChromOutput = 8'h01;
    sif2.iExpectedOutput = 8'h00; sif2.iValidMask = 8'h01;
    step(15);
    @(negedge clk);
    chk("t6_lane0_at15", 64'(sums2[0 +: SW2]), 64'd15);
    chk("t6_ready_mid", 64'(sif2.oSampleReady), 64'd1);
    step(5);
    sif2.iSampleValid = 1'b0;
    @(negedge clk);
`ifdef ERROR_SUM_SATURATE_EN
    chk("t6_lane0_final", 64'(sums2[0 +: SW2]), 64'd15);
    chk("t6_total_final", 64'(total2), 64'd15);
`else
    chk("t6_lane0_final", 64'(sums2[0 +: SW2]), 64'd4);
    chk("t6_total_final", 64'(total2), 64'd4);
`endif
    chk("t6_lane1", 64'(sums2[SW2 +: SW2]), 64'd0);
    chk("t6_index", 64'(idx2), 64'd20);
    chk("t6_done", 64'(done2), 64'd1);
    chk("t6_state", 64'(st2), 64'd2);
    fb2 = 1'b1;
    step(1);
    fb2 = 1'b0;
    step(1);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
